// File: rtl/tbuart_pkg.sv
// Shared types and constants for the tbuart 8N1 receiver.
// The optional parity stage is enabled by defining TBUART_PARITY_EN.
package tbuart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam int         TIMER_W  = 16;

    // Half a bit period, used to land the start-bit check mid-bit.
    function automatic logic [TIMER_W-1:0] half_bit_count(input int clksPerBit);
        return TIMER_W'(clksPerBit / 2);
    endfunction

endpackage

// File: rtl/tbuart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset to RESET_VAL so an idle-high line reads as idle.
module tbuart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic resetb,
    input  logic din_i,
    output logic dout_o
);

    logic [1:0] stage_q;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            stage_q <= {2{RESET_VAL}};
        end else begin
            stage_q <= {stage_q[0], din_i};
        end
    end

    assign dout_o = stage_q[1];

endmodule

// File: rtl/tbuart_rx.sv
// 8N1 UART receiver/monitor with byte strobe, line-feed strobe and char counter.
// Define TBUART_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
module tbuart_rx
    import tbuart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 347,
    parameter int CNT_W        = 16
`ifdef TBUART_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             ser_rx,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             frame_err,
    output logic             line_done,
    output logic             busy,
    output logic [CNT_W-1:0] char_count
);

    localparam logic [TIMER_W-1:0] FULL_BIT = TIMER_W'(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0] HALF_BIT = half_bit_count(CLKS_PER_BIT);

    logic rxS;

    tbuart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clock  (clock),
        .resetb (resetb),
        .din_i  (ser_rx),
        .dout_o (rxS)
    );

    state_t             state_q;
    logic [TIMER_W-1:0] cnt_q;
    logic [2:0]         bitIdx_q;
    logic [7:0]         shift_q;
    logic [7:0]         shift_d;
    logic [7:0]         rxData_q;
    logic               rxValid_q;
    logic               frameErr_q;
    logic               lineDone_q;
    logic [CNT_W-1:0]   charCount_q;
    logic               expire;
`ifdef TBUART_PARITY_EN
    logic               parErr_q;
`endif

    // A loaded count of N expires exactly N cycles after the load.
    assign expire  = (cnt_q == TIMER_W'(1));
    assign shift_d = {rxS, shift_q[7:1]};

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            rxData_q    <= '0;
            rxValid_q   <= 1'b0;
            frameErr_q  <= 1'b0;
            lineDone_q  <= 1'b0;
            charCount_q <= '0;
`ifdef TBUART_PARITY_EN
            parErr_q    <= 1'b0;
`endif
        end else begin
            rxValid_q  <= 1'b0;
            frameErr_q <= 1'b0;
            lineDone_q <= 1'b0;
            if (state_q != IDLE && state_q != BREAK && !expire) begin
                cnt_q <= cnt_q - TIMER_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (!rxS) begin
                        cnt_q   <= HALF_BIT;
                        state_q <= START;
                    end
                end
                START: begin
                    if (expire) begin
                        if (rxS) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q    <= FULL_BIT;
                            bitIdx_q <= '0;
`ifdef TBUART_PARITY_EN
                            parErr_q <= 1'b0;
`endif
                            state_q  <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (expire) begin
                        shift_q <= shift_d;
                        cnt_q   <= FULL_BIT;
                        if (bitIdx_q == 3'd7) begin
`ifdef TBUART_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            bitIdx_q <= bitIdx_q + 3'd1;
                        end
                    end
                end
`ifdef TBUART_PARITY_EN
                PARITY: begin
                    if (expire) begin
                        parErr_q <= ((^shift_q) ^ rxS) != PARITY_ODD;
                        cnt_q    <= FULL_BIT;
                        state_q  <= STOP;
                    end
                end
`endif
                // Leave mid-stop-bit so an immediately following start edge is seen.
                STOP: begin
                    if (expire) begin
                        if (!rxS) begin
                            frameErr_q <= 1'b1;
                            state_q    <= BREAK;
`ifdef TBUART_PARITY_EN
                        end else if (parErr_q) begin
                            frameErr_q <= 1'b1;
                            state_q    <= IDLE;
`endif
                        end else begin
                            rxValid_q   <= 1'b1;
                            rxData_q    <= shift_q;
                            lineDone_q  <= (shift_q == ASCII_LF);
                            charCount_q <= charCount_q + CNT_W'(1);
                            state_q     <= IDLE;
                        end
                    end
                end
                BREAK: begin
                    if (rxS) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rx_data    = rxData_q;
    assign rx_valid   = rxValid_q;
    assign frame_err  = frameErr_q;
    assign line_done  = lineDone_q;
    assign char_count = charCount_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_tbuart_rx.sv
// Self-checking bench for tbuart_rx at CLKS_PER_BIT=8.
// Define TBUART_PARITY_EN to also exercise the even-parity path.
module tb_tbuart_rx;

    localparam int C     = 8;
    localparam int CNT_W = 16;

    logic             clock;
    logic             resetb;
    logic             ser_rx;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             frame_err;
    logic             line_done;
    logic             busy;
    logic [CNT_W-1:0] char_count;

    int passCount  = 0;
    int checkCount = 0;

    // Monitor tallies, written only by the monitor process.
    int         validCnt  = 0;
    int         errCnt    = 0;
    int         lfCnt     = 0;
    int         badLfCnt  = 0;
    int         bothCnt   = 0;
    logic [7:0] rxQ[$];

    // Reference model state: what a correct receiver should report.
    int         expCount = 0;
    logic [7:0] expData  = 8'h00;

    tbuart_rx #(.CLKS_PER_BIT(C), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .resetb     (resetb),
        .ser_rx     (ser_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .line_done  (line_done),
        .busy       (busy),
        .char_count (char_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record every strobe seen on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (resetb) begin
            if (rx_valid) begin
                validCnt++;
                rxQ.push_back(rx_data);
            end
            if (frame_err) errCnt++;
            if (line_done) lfCnt++;
            if (line_done && (!rx_valid || rx_data !== 8'h0A)) badLfCnt++;
            if (line_done == 1'b0 && rx_valid && rx_data === 8'h0A) badLfCnt++;
            if (rx_valid && frame_err) bothCnt++;
        end
    end

    // Hold one bit level for a full bit period, starting on a falling edge.
    task automatic driveBit(input logic b);
        ser_rx = b;
        repeat (C) @(negedge clock);
    endtask

    // Drive a whole frame; parityBit is only sent when parity is enabled.
    task automatic sendFrame(input logic [7:0] data, input logic parityBit, input logic stopBit);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
`ifdef TBUART_PARITY_EN
        driveBit(parityBit);
`else
        if (parityBit) begin end
`endif
        driveBit(stopBit);
    endtask

    function automatic logic goodParity(input logic [7:0] data);
        return ^data;
    endfunction

    // Model bookkeeping for a frame that should be accepted.
    task automatic modelAccept(input logic [7:0] data);
        expCount++;
        expData = data;
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        ser_rx = 1'b1;
        repeat (3) @(negedge clock);
        checkCount++;
        if (rx_data !== 8'h00) $display("[TB] FAIL reset_rx_data got %h want 00", rx_data);
        else passCount++;
        checkCount++;
        if (char_count !== '0) $display("[TB] FAIL reset_char_count got %0d want 0", char_count);
        else passCount++;
        checkCount++;
        if ({rx_valid, frame_err, line_done, busy} !== 4'b0000)
            $display("[TB] FAIL reset_strobes got %b want 0000", {rx_valid, frame_err, line_done, busy});
        else passCount++;
        resetb = 1'b1;
        repeat (4) @(negedge clock);
        checkCount++;
        if (busy !== 1'b0) $display("[TB] FAIL idle_busy got %b want 0", busy);
        else passCount++;
    endtask

    task automatic test_basic_latency();
        int n;
        int v0;
        int expLat;
        v0     = validCnt;
        expLat = 2 + C / 2 + 9 * C + 1;
        n      = 0;
        fork
            sendFrame(8'h55, goodParity(8'h55), 1'b1);
            begin
                while (n < 200) begin
                    @(posedge clock);
                    n++;
                    #1;
                    if (rx_valid) break;
                end
            end
        join
        modelAccept(8'h55);
        repeat (2) @(negedge clock);
        checkCount++;
        if (n !== expLat) $display("[TB] FAIL latency got %0d cycles want %0d", n, expLat);
        else passCount++;
        checkCount++;
        if (rx_data !== expData) $display("[TB] FAIL basic_data got %h want %h", rx_data, expData);
        else passCount++;
        checkCount++;
        if (char_count !== CNT_W'(expCount))
            $display("[TB] FAIL basic_count got %0d want %0d", char_count, expCount);
        else passCount++;
        checkCount++;
        if (validCnt - v0 !== 1) $display("[TB] FAIL basic_strobes got %0d want 1", validCnt - v0);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        int v0;
        int l0;
        logic [7:0] a;
        logic [7:0] b;
        v0 = validCnt;
        l0 = lfCnt;
        rxQ.delete();
        sendFrame(8'h41, goodParity(8'h41), 1'b1);
        sendFrame(8'h0A, goodParity(8'h0A), 1'b1);
        modelAccept(8'h41);
        modelAccept(8'h0A);
        driveBit(1'b1);
        checkCount++;
        if (validCnt - v0 !== 2) $display("[TB] FAIL b2b_strobes got %0d want 2", validCnt - v0);
        else passCount++;
        a = (rxQ.size() > 0) ? rxQ[0] : 8'hxx;
        b = (rxQ.size() > 1) ? rxQ[1] : 8'hxx;
        checkCount++;
        if (a !== 8'h41 || b !== 8'h0A) $display("[TB] FAIL b2b_bytes got %h,%h want 41,0a", a, b);
        else passCount++;
        checkCount++;
        if (lfCnt - l0 !== 1) $display("[TB] FAIL b2b_line_done got %0d want 1", lfCnt - l0);
        else passCount++;
        checkCount++;
        if (char_count !== CNT_W'(expCount))
            $display("[TB] FAIL b2b_count got %0d want %0d", char_count, expCount);
        else passCount++;
    endtask

    task automatic test_glitch();
        int v0;
        int busyCycles;
        v0         = validCnt;
        busyCycles = 0;
        ser_rx = 1'b0;
        repeat (2) @(negedge clock);
        ser_rx = 1'b1;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (busy) busyCycles++;
        end
        checkCount++;
        if (busyCycles !== C / 2) $display("[TB] FAIL glitch_busy got %0d want %0d", busyCycles, C / 2);
        else passCount++;
        checkCount++;
        if (validCnt - v0 !== 0 || char_count !== CNT_W'(expCount))
            $display("[TB] FAIL glitch_nostrobe got %0d/%0d want 0/%0d", validCnt - v0, char_count, expCount);
        else passCount++;
        @(negedge clock);
    endtask

    task automatic test_frame_error();
        int v0;
        int e0;
        v0 = validCnt;
        e0 = errCnt;
        sendFrame(8'hA1, goodParity(8'hA1), 1'b0);
        repeat (20 * C) @(negedge clock);
        checkCount++;
        if (busy !== 1'b1) $display("[TB] FAIL break_busy got %b want 1", busy);
        else passCount++;
        driveBit(1'b1);
        driveBit(1'b1);
        checkCount++;
        if (errCnt - e0 !== 1) $display("[TB] FAIL break_errs got %0d want 1", errCnt - e0);
        else passCount++;
        checkCount++;
        if (validCnt - v0 !== 0 || rx_data !== expData)
            $display("[TB] FAIL break_data got %0d strobes data %h want 0 strobes data %h", validCnt - v0, rx_data, expData);
        else passCount++;
        sendFrame(8'h33, goodParity(8'h33), 1'b1);
        modelAccept(8'h33);
        driveBit(1'b1);
        checkCount++;
        if (rx_data !== expData || char_count !== CNT_W'(expCount))
            $display("[TB] FAIL after_break got %h/%0d want %h/%0d", rx_data, char_count, expData, expCount);
        else passCount++;
    endtask

    task automatic test_reset_midframe();
        int v0;
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(1'b1);
        ser_rx = 1'b1;
        repeat (C / 2) @(negedge clock);
        resetb = 1'b0;
        ser_rx = 1'b1;
        expCount = 0;
        expData  = 8'h00;
        #1;
        checkCount++;
        if ({rx_data, rx_valid, frame_err, line_done, busy} !== 12'h000 || char_count !== '0)
            $display("[TB] FAIL midreset_outputs got %h %b%b%b%b %0d want 00 0000 0",
                     rx_data, rx_valid, frame_err, line_done, busy, char_count);
        else passCount++;
        repeat (3) @(negedge clock);
        resetb = 1'b1;
        repeat (2 * C) @(negedge clock);
        v0 = validCnt;
        checkCount++;
        if (v0 !== validCnt || busy !== 1'b0) $display("[TB] FAIL midreset_idle got busy %b want 0", busy);
        else passCount++;
        sendFrame(8'h00, goodParity(8'h00), 1'b1);
        modelAccept(8'h00);
        driveBit(1'b1);
        checkCount++;
        if (validCnt - v0 !== 1 || rx_data !== expData || char_count !== CNT_W'(expCount))
            $display("[TB] FAIL midreset_next got %0d strobes %h/%0d want 1 strobe %h/%0d",
                     validCnt - v0, rx_data, char_count, expData, expCount);
        else passCount++;
    endtask

    task automatic test_random();
        logic [7:0] sent[$];
        logic [7:0] b;
        int         gap;
        int         errs;
        rxQ.delete();
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(0, 255));
            sent.push_back(b);
            sendFrame(b, goodParity(b), 1'b1);
            modelAccept(b);
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                ser_rx = 1'b1;
                repeat (gap) @(negedge clock);
            end
        end
        driveBit(1'b1);
        checkCount++;
        if (rxQ.size() !== sent.size()) $display("[TB] FAIL random_count got %0d want %0d", rxQ.size(), sent.size());
        else passCount++;
        errs = 0;
        for (int i = 0; i < sent.size() && i < rxQ.size(); i++) begin
            if (rxQ[i] !== sent[i]) errs++;
        end
        checkCount++;
        if (errs !== 0) $display("[TB] FAIL random_bytes got %0d wrong want 0", errs);
        else passCount++;
        checkCount++;
        if (rx_data !== expData || char_count !== CNT_W'(expCount))
            $display("[TB] FAIL random_final got %h/%0d want %h/%0d", rx_data, char_count, expData, expCount);
        else passCount++;
    endtask

`ifdef TBUART_PARITY_EN
    task automatic test_parity();
        int v0;
        int e0;
        v0 = validCnt;
        e0 = errCnt;
        sendFrame(8'h07, 1'b0, 1'b1);
        driveBit(1'b1);
        checkCount++;
        if (errCnt - e0 !== 1 || validCnt - v0 !== 0)
            $display("[TB] FAIL parity_bad got %0d errs %0d strobes want 1 and 0", errCnt - e0, validCnt - v0);
        else passCount++;
        sendFrame(8'h07, 1'b1, 1'b1);
        modelAccept(8'h07);
        driveBit(1'b1);
        checkCount++;
        if (validCnt - v0 !== 1 || rx_data !== expData)
            $display("[TB] FAIL parity_good got %0d strobes %h want 1 strobe %h", validCnt - v0, rx_data, expData);
        else passCount++;
    endtask
`endif

    task automatic test_invariants();
        checkCount++;
        if (bothCnt !== 0) $display("[TB] FAIL valid_and_err got %0d overlaps want 0", bothCnt);
        else passCount++;
        checkCount++;
        if (badLfCnt !== 0) $display("[TB] FAIL line_done_align got %0d bad want 0", badLfCnt);
        else passCount++;
    endtask

    initial begin
        resetb = 1'b0;
        ser_rx = 1'b1;
        @(negedge clock);
        test_reset();
        test_basic_latency();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_midframe();
        test_random();
`ifdef TBUART_PARITY_EN
        test_parity();
`endif
        test_invariants();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout got no finish want finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
